// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB writeback inputs, decode read ports and retire/status outputs of the writeback stage.
interface wb_regfile_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
);
   logic             stall;
   logic             RegWrite_MEM;
   logic [1:0]       ResultSrc_MEM;
   logic [XLEN-1:0]  ALUresult_MEM;
   logic [XLEN-1:0]  MemReadData_MEM;
   logic [XLEN-1:0]  PC_next_MEM;
   logic [4:0]       rd_EXMEM_MEM;
   logic [4:0]       rs1_addr;
   logic [4:0]       rs2_addr;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic [XLEN-1:0]  wb_result;
   logic             wb_en;
   logic [4:0]       wb_rd;
   logic [CNT_W-1:0] instret;
   logic             illegal_wb;
   modport master (
      output stall, RegWrite_MEM, ResultSrc_MEM, ALUresult_MEM, MemReadData_MEM, PC_next_MEM,
             rd_EXMEM_MEM, rs1_addr, rs2_addr,
      input  rs1_data, rs2_data, wb_result, wb_en, wb_rd, instret, illegal_wb
   );
   modport slave (
      input  stall, RegWrite_MEM, ResultSrc_MEM, ALUresult_MEM, MemReadData_MEM, PC_next_MEM,
             rd_EXMEM_MEM, rs1_addr, rs2_addr,
      output rs1_data, rs2_data, wb_result, wb_en, wb_rd, instret, illegal_wb
   );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback result select, 32x32 register file with write-to-read bypass, retire counter and sticky illegal-select flag.
module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input logic         clk,
   input logic         rst,
   wb_regfile_if.slave bus
);
   logic [XLEN-1:0]  r_regs [32];
   logic [CNT_W-1:0] r_instret;
   logic             r_illegal;
   logic             w_legal;
   logic             w_wb_en;
   logic [XLEN-1:0]  w_result;
   always_comb begin
      w_legal  = bus.ResultSrc_MEM != 2'b11;
      w_result = bus.ResultSrc_MEM == 2'b00 ? bus.ALUresult_MEM :
                 bus.ResultSrc_MEM == 2'b01 ? bus.MemReadData_MEM :
                 bus.ResultSrc_MEM == 2'b10 ? bus.PC_next_MEM : '0;
      w_wb_en  = bus.RegWrite_MEM & w_legal & (bus.rd_EXMEM_MEM != 5'd0);
   end
   // A stalled instruction is held in WB; it commits only on the first unstalled edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
         r_instret <= '0;
         r_illegal <= 1'b0;
      end else if (!bus.stall) begin
         if (w_wb_en) r_regs[bus.rd_EXMEM_MEM] <= w_result;
         if (bus.RegWrite_MEM | w_legal) r_instret <= r_instret + CNT_W'(1);
         if (bus.RegWrite_MEM & ~w_legal) r_illegal <= 1'b1;
      end
   end
   always_comb begin
      bus.rs1_data = bus.rs1_addr == 5'd0 ? '0 :
                     (w_wb_en && bus.rs1_addr == bus.rd_EXMEM_MEM) ? w_result : r_regs[bus.rs1_addr];
      bus.rs2_data = bus.rs2_addr == 5'd0 ? '0 :
                     (w_wb_en && bus.rs2_addr == bus.rd_EXMEM_MEM) ? w_result : r_regs[bus.rs2_addr];
   end
   assign bus.wb_result  = w_result;
   assign bus.wb_en      = w_wb_en;
   assign bus.wb_rd      = bus.rd_EXMEM_MEM;
   assign bus.instret    = r_instret;
   assign bus.illegal_wb = r_illegal;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed tests for wb_regfile; a second CNT_W=4 instance covers counter wrap.
module tb_wb_regfile;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   always #5 clk = ~clk;
   wb_regfile_if #(.XLEN(32), .CNT_W(64)) ifa ();
   wb_regfile_if #(.XLEN(32), .CNT_W(4))  ifb ();
   wb_regfile #(.XLEN(32), .CNT_W(64)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   wb_regfile #(.XLEN(32), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb));
   // Idle slot: no write and not counted (RegWrite=0, ResultSrc=11).
   task automatic idle();
      ifa.stall = 1'b0;
      ifa.RegWrite_MEM = 1'b0;
      ifa.ResultSrc_MEM = 2'b11;
      ifa.ALUresult_MEM = '0;
      ifa.MemReadData_MEM = '0;
      ifa.PC_next_MEM = '0;
      ifa.rd_EXMEM_MEM = '0;
   endtask
   task automatic drive(input logic rw, input logic [1:0] src, input logic [4:0] rd, input logic [31:0] alu);
      ifa.RegWrite_MEM = rw;
      ifa.ResultSrc_MEM = src;
      ifa.rd_EXMEM_MEM = rd;
      ifa.ALUresult_MEM = alu;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 2'b00, 5'd5, 32'hDEAD);
      @(negedge clk);
      idle();
      ifa.rs1_addr = 5'd5;
      #1;
      n_tests++;
      if (ifa.rs1_data !== 32'hDEAD) begin n_fail++; $display("FAIL reset_preload: got %h expected %h", ifa.rs1_data, 32'hDEAD); end
      drive(1'b1, 2'b00, 5'd5, 32'hBEEF);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle();
      #1;
      n_tests++;
      if (ifa.rs1_data !== 32'h0) begin n_fail++; $display("FAIL reset_x5: got %h expected 0", ifa.rs1_data); end
      n_tests++;
      if (ifa.instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret: got %0h expected 0", ifa.instret); end
      n_tests++;
      if (ifa.illegal_wb !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", ifa.illegal_wb); end
      n_tests++;
      if (ifa.wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_idle_wb_en: got %b expected 0", ifa.wb_en); end
   endtask
   task automatic test_select();
      logic [31:0] exp [3] = '{32'h11, 32'h22, 32'h33};
      ifa.MemReadData_MEM = 32'h22;
      ifa.PC_next_MEM = 32'h33;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 2'(k), 5'd3, 32'h11);
         ifa.MemReadData_MEM = 32'h22;
         ifa.PC_next_MEM = 32'h33;
         ifa.rs1_addr = 5'd1;
         #1;
         n_tests++;
         if (ifa.wb_result !== exp[k]) begin n_fail++; $display("FAIL select_wb_result[%0d]: got %h expected %h", k, ifa.wb_result, exp[k]); end
         @(negedge clk);
         idle();
         ifa.rs2_addr = 5'd3;
         #1;
         n_tests++;
         if (ifa.rs2_data !== exp[k]) begin n_fail++; $display("FAIL select_x3[%0d]: got %h expected %h", k, ifa.rs2_data, exp[k]); end
      end
      n_tests++;
      if (ifa.instret !== 64'd3) begin n_fail++; $display("FAIL select_instret: got %0h expected 3", ifa.instret); end
      drive(1'b0, 2'b00, 5'd3, 32'h99);
      @(negedge clk);
      idle();
      #1;
      n_tests++;
      if (ifa.instret !== 64'd4) begin n_fail++; $display("FAIL bubble_instret: got %0h expected 4", ifa.instret); end
      n_tests++;
      if (ifa.rs2_data !== 32'h33) begin n_fail++; $display("FAIL bubble_no_write: got %h expected 33", ifa.rs2_data); end
   endtask
   task automatic test_bypass();
      drive(1'b1, 2'b00, 5'd7, 32'h1);
      @(negedge clk);
      drive(1'b1, 2'b00, 5'd7, 32'hCAFE);
      ifa.rs1_addr = 5'd7;
      ifa.rs2_addr = 5'd7;
      #1;
      n_tests++;
      if (ifa.rs1_data !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_rs1: got %h expected cafe", ifa.rs1_data); end
      n_tests++;
      if (ifa.rs2_data !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_rs2: got %h expected cafe", ifa.rs2_data); end
      n_tests++;
      if (ifa.wb_en !== 1'b1 || ifa.wb_rd !== 5'd7) begin n_fail++; $display("FAIL bypass_wb_en_rd: got %b/%0d expected 1/7", ifa.wb_en, ifa.wb_rd); end
      @(negedge clk);
      idle();
      #1;
      n_tests++;
      if (ifa.rs1_data !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_array: got %h expected cafe", ifa.rs1_data); end
   endtask
   task automatic test_stall();
      drive(1'b1, 2'b00, 5'd9, 32'h5);
      ifa.stall = 1'b1;
      ifa.rs1_addr = 5'd9;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (ifa.rs1_data !== 32'h5) begin n_fail++; $display("FAIL stall_bypass[%0d]: got %h expected 5", c, ifa.rs1_data); end
         @(negedge clk);
      end
      ifa.RegWrite_MEM = 1'b0;
      #1;
      n_tests++;
      if (ifa.rs1_data !== 32'h0) begin n_fail++; $display("FAIL stall_array: got %h expected 0", ifa.rs1_data); end
      n_tests++;
      if (ifa.instret !== 64'd6) begin n_fail++; $display("FAIL stall_instret_flat: got %0h expected 6", ifa.instret); end
      ifa.RegWrite_MEM = 1'b1;
      ifa.stall = 1'b0;
      @(negedge clk);
      idle();
      #1;
      n_tests++;
      if (ifa.rs1_data !== 32'h5) begin n_fail++; $display("FAIL stall_release_write: got %h expected 5", ifa.rs1_data); end
      n_tests++;
      if (ifa.instret !== 64'd7) begin n_fail++; $display("FAIL stall_release_instret: got %0h expected 7", ifa.instret); end
   endtask
   task automatic test_x0_illegal();
      drive(1'b1, 2'b00, 5'd0, 32'hFFFF);
      ifa.rs1_addr = 5'd0;
      #1;
      n_tests++;
      if (ifa.rs1_data !== 32'h0) begin n_fail++; $display("FAIL x0_read: got %h expected 0", ifa.rs1_data); end
      n_tests++;
      if (ifa.wb_en !== 1'b0) begin n_fail++; $display("FAIL x0_wb_en: got %b expected 0", ifa.wb_en); end
      @(negedge clk);
      drive(1'b1, 2'b11, 5'd4, 32'h77);
      ifa.rs1_addr = 5'd4;
      #1;
      n_tests++;
      if (ifa.wb_en !== 1'b0 || ifa.wb_result !== 32'h0) begin n_fail++; $display("FAIL illegal_comb: got %b/%h expected 0/0", ifa.wb_en, ifa.wb_result); end
      n_tests++;
      if (ifa.illegal_wb !== 1'b0) begin n_fail++; $display("FAIL illegal_before: got %b expected 0", ifa.illegal_wb); end
      @(negedge clk);
      idle();
      #1;
      n_tests++;
      if (ifa.rs1_data !== 32'h0) begin n_fail++; $display("FAIL illegal_x4: got %h expected 0", ifa.rs1_data); end
      n_tests++;
      if (ifa.illegal_wb !== 1'b1) begin n_fail++; $display("FAIL illegal_set: got %b expected 1", ifa.illegal_wb); end
      n_tests++;
      if (ifa.instret !== 64'd9) begin n_fail++; $display("FAIL illegal_instret: got %0h expected 9", ifa.instret); end
      repeat (2) @(negedge clk);
      n_tests++;
      if (ifa.illegal_wb !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky: got %b expected 1", ifa.illegal_wb); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if (ifa.illegal_wb !== 1'b0) begin n_fail++; $display("FAIL illegal_cleared: got %b expected 0", ifa.illegal_wb); end
   endtask
   task automatic test_wrap();
      n_tests++;
      if (ifb.instret !== 4'd0) begin n_fail++; $display("FAIL wrap_start: got %0d expected 0", ifb.instret); end
      ifb.stall = 1'b0;
      repeat (15) @(negedge clk);
      #1;
      n_tests++;
      if (ifb.instret !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d expected 15", ifb.instret); end
      @(negedge clk);
      ifb.stall = 1'b1;
      #1;
      n_tests++;
      if (ifb.instret !== 4'd0) begin n_fail++; $display("FAIL wrap_16: got %0d expected 0", ifb.instret); end
   endtask
   initial begin
      idle();
      ifa.rs1_addr = '0;
      ifa.rs2_addr = '0;
      ifb.stall = 1'b1;
      ifb.RegWrite_MEM = 1'b0;
      ifb.ResultSrc_MEM = 2'b00;
      ifb.ALUresult_MEM = '0;
      ifb.MemReadData_MEM = '0;
      ifb.PC_next_MEM = '0;
      ifb.rd_EXMEM_MEM = '0;
      ifb.rs1_addr = '0;
      ifb.rs2_addr = '0;
      @(negedge clk);
      test_reset();
      test_select();
      test_bypass();
      test_stall();
      test_x0_illegal();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
